branch_resolve_queue: RTL and testbench

- In-order FIFO of in-flight conditional-branch predictions.
- Fetch pushes one entry per predicted branch. When EX resolves the oldest branch, the entry is compared against the actual outcome.
- Drives the direction predictor's update port (predict_en / resolved_pc / predictionFailed) and the pipeline redirect on a misprediction.
- Sits between IF/EX and the local prediction table.

---
 rtl/branch_resolve_queue_pkg.sv | 33 +++
 rtl/branch_resolve_queue_outcome_check.sv | 33 +++
 rtl/branch_resolve_queue.sv | 152 +++++++++++++++
 tb/tb_branch_resolve_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue.
//   datapath_mux_types      : predictmux_t, the predicted-direction encoding
//   rv32i_types             : rv32i_word and brq_entry_t (pc, dir, target)
//   branch_resolve_queue_pkg: queue-local constants
// No ports; these packages are imported by the queue, its outcome checker
// and the bench.

package datapath_mux_types;
    typedef enum logic {
        nottaken = 1'b0,
        taken    = 1'b1
    } predictmux_t;
endpackage

package rv32i_types;
    import datapath_mux_types::*;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word   pc;
        predictmux_t dir;
        rv32i_word   target;
    } brq_entry_t;
endpackage

package branch_resolve_queue_pkg;
    import rv32i_types::*;

    localparam int        BRQ_DEPTH_DEFAULT = 8;
    // Size of one RV32I instruction; the fall-through PC is pc + INSTR_BYTES.
    localparam rv32i_word INSTR_BYTES       = 32'd4;
endpackage

// File: rtl/branch_resolve_queue_outcome_check.sv
// brq_outcome_check: combinational comparison of one queued prediction
// against the actual branch outcome from EX.
// Ports:
//   entry          in  : queued prediction (pc, dir, target)
//   resolve_taken  in  : actual direction
//   resolve_target in  : actual target when taken
//   dir_fail       out : predicted direction differs from actual
//   mispredict     out : direction miss, or taken-taken with a wrong target
//   redirect_pc    out : correct next PC (target if taken, else pc+4, wrapping)

module brq_outcome_check
    import datapath_mux_types::*;
    import rv32i_types::*;
    import branch_resolve_queue_pkg::*;
(
    input  brq_entry_t entry,
    input  logic       resolve_taken,
    input  rv32i_word  resolve_target,
    output logic       dir_fail,
    output logic       mispredict,
    output rv32i_word  redirect_pc
);
    logic pred_taken;
    logic target_miss;

    assign pred_taken  = (entry.dir == taken);
    assign dir_fail    = (pred_taken != resolve_taken);
    // A target miss is only meaningful when both prediction and outcome are taken;
    // it redirects the pipeline but is not reported as a direction failure.
    assign target_miss = resolve_taken && pred_taken && (entry.target != resolve_target);
    assign mispredict  = dir_fail || target_miss;
    assign redirect_pc = resolve_taken ? resolve_target : (entry.pc + INSTR_BYTES);
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of in-flight conditional-branch
// predictions. Fetch pushes one entry per predicted branch; EX resolves the
// oldest one, which drives the predictor update port and, on a miss, a
// one-cycle redirect pulse while all younger (wrong-path) entries are flushed.
//
// Optional build macro: BRQ_STATS_EN enables saturating resolved-branch and
// misprediction counters; without it stat_* are tied to 0.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_pc, push_dir, push_target : fetch-side enqueue
//   full, empty, count  : occupancy
//   resolve_valid, resolve_taken, resolve_target : EX-side resolve of head
//   upd_en, upd_pc, upd_failed : predictor update (registered, 1-cycle latency)
//   mispredict, redirect_pc    : flush/redirect (registered, 1-cycle latency)
//   resolve_err         : sticky, resolve seen while empty
//   stat_branches, stat_mispredicts : statistics counters
//
// Handshake: push is accepted when !full, or when the head pops in the same
// cycle; a push that is refused is dropped, so fetch must stall on full.
// resolve_valid has no ready: it always pops the head when one exists.

module branch_resolve_queue
    import datapath_mux_types::*;
    import rv32i_types::*;
    import branch_resolve_queue_pkg::*;
#(
    parameter  int DEPTH = BRQ_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  rv32i_word         push_pc,
    input  predictmux_t       push_dir,
    input  rv32i_word         push_target,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  rv32i_word         resolve_target,
    output logic              upd_en,
    output rv32i_word         upd_pc,
    output logic              upd_failed,
    output logic              mispredict,
    output rv32i_word         redirect_pc,
    output logic              resolve_err,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    brq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    brq_entry_t head_entry;
    brq_entry_t push_entry;
    logic       pop;
    logic       flush;
    logic       push_ok;
    logic       chk_dir_fail;
    logic       chk_mispredict;
    rv32i_word  chk_redirect_pc;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = mem[head];
    assign push_entry = '{pc: push_pc, dir: push_dir, target: push_target};

    brq_outcome_check u_check (
        .entry          (head_entry),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .dir_fail       (chk_dir_fail),
        .mispredict     (chk_mispredict),
        .redirect_pc    (chk_redirect_pc)
    );

    assign pop     = resolve_valid && !empty;
    // Everything younger than a mispredicted branch is wrong-path, including
    // a branch fetch tries to push in the same cycle.
    assign flush   = pop && chk_mispredict;
    assign push_ok = push && (!full || pop) && !flush;

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            upd_en      <= 1'b0;
            upd_pc      <= '0;
            upd_failed  <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            resolve_err <= 1'b0;
        end else begin
            upd_en     <= pop;
            mispredict <= flush;
            if (pop) begin
                head        <= head + PTR_ONE;
                upd_pc      <= head_entry.pc;
                upd_failed  <= chk_dir_fail;
                redirect_pc <= chk_redirect_pc;
            end
            if (resolve_valid && empty) begin
                resolve_err <= 1'b1;
            end
            if (flush) begin
                tail  <= head + PTR_ONE;
                count <= '0;
            end else begin
                if (push_ok) begin
                    tail <= tail + PTR_ONE;
                end
                if (push_ok && !pop) begin
                    count <= count + CNT_ONE;
                end else if (!push_ok && pop) begin
                    count <= count - CNT_ONE;
                end
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pop && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (flush && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue (DEPTH = 8). Directed stimulus; each resolve
// pushes its hand-computed update into exp_q and a negedge monitor pops and
// compares whenever upd_en is presented. Occupancy and sticky flags are
// checked directly by the driver.

module tb_branch_resolve_queue;
    import datapath_mux_types::*;
    import rv32i_types::*;

    localparam int DEPTH = 8;
    localparam int EXP_W = 66;   // {upd_pc, upd_failed, mispredict, redirect_pc}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    rv32i_word   push_pc = '0;
    predictmux_t push_dir = nottaken;
    rv32i_word   push_target = '0;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    rv32i_word   resolve_target = '0;
    logic        upd_en;
    rv32i_word   upd_pc;
    logic        upd_failed;
    logic        mispredict;
    rv32i_word   redirect_pc;
    logic        resolve_err;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_pc(push_pc), .push_dir(push_dir), .push_target(push_target),
        .full(full), .empty(empty), .count(count),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_failed(upd_failed),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .resolve_err(resolve_err),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_upd(input rv32i_word pc, input logic failed, input logic mis,
                              input rv32i_word redir);
        exp_q.push_back({pc, failed, mis, redir});
    endtask

    // One clock of stimulus; returns #1 after the capturing edge.
    task automatic step(input logic p, input rv32i_word pc, input predictmux_t dir,
                        input rv32i_word tgt, input logic rv, input logic rt,
                        input rv32i_word rtgt);
        push           = p;
        push_pc        = pc;
        push_dir       = dir;
        push_target    = tgt;
        resolve_valid  = rv;
        resolve_taken  = rt;
        resolve_target = rtgt;
        @(posedge clk);
        #1;
        push          = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic do_push(input rv32i_word pc, input predictmux_t dir, input rv32i_word tgt);
        step(1'b1, pc, dir, tgt, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_resolve(input logic rt, input rv32i_word rtgt);
        step(1'b0, 32'h0, nottaken, 32'h0, 1'b1, rt, rtgt);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, nottaken, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst) begin
            if (upd_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: upd_en=1 upd_pc=0x%08h with no update expected at %0t",
                             upd_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("upd_pc", upd_pc, e[65:34]);
                    check("upd_failed", {31'b0, upd_failed}, {31'b0, e[33]});
                    check("mispredict", {31'b0, mispredict}, {31'b0, e[32]});
                    check("redirect_pc", redirect_pc, e[31:0]);
                end
            end else if (mispredict === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL stray_mispredict: mispredict=1 without upd_en at %0t", $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        rst = 1'b1;
        idle();
        idle();
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_upd_en", {31'b0, upd_en}, 32'd0);
        check("rst_upd_pc", upd_pc, 32'd0);
        check("rst_upd_failed", {31'b0, upd_failed}, 32'd0);
        check("rst_mispredict", {31'b0, mispredict}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_resolve_err", {31'b0, resolve_err}, 32'd0);
        check("rst_stat_branches", stat_branches, 32'd0);
        check("rst_stat_mispredicts", stat_mispredicts, 32'd0);
        rst = 1'b0;
        idle();

        // Correct taken prediction
        do_push(32'h100, taken, 32'h200);
        check("t1_count_after_push", {28'b0, count}, 32'd1);
        expect_upd(32'h100, 1'b0, 1'b0, 32'h200);
        do_resolve(1'b1, 32'h200);
        check("t1_count", {28'b0, count}, 32'd0);
        idle();
        check("t1_upd_en_drops", {31'b0, upd_en}, 32'd0);
        check("t1_upd_pc_holds", upd_pc, 32'h100);

        // Direction miss flushes the younger entry and a same-cycle push
        do_push(32'h100, nottaken, 32'h0);
        do_push(32'h140, taken, 32'h999);
        check("t2_count_two", {28'b0, count}, 32'd2);
        expect_upd(32'h100, 1'b1, 1'b1, 32'h180);
        step(1'b1, 32'h500, taken, 32'h600, 1'b1, 1'b1, 32'h180);
        check("t2_count_flushed", {28'b0, count}, 32'd0);
        check("t2_empty", {31'b0, empty}, 32'd1);
        idle();

        // Target-only miss
        do_push(32'h300, taken, 32'h400);
        expect_upd(32'h300, 1'b0, 1'b1, 32'h480);
        do_resolve(1'b1, 32'h480);
        check("t3_count", {28'b0, count}, 32'd0);
        idle();

        // Fill, overflow drop, push+pop at full, wrap-around order
        for (int i = 0; i < DEPTH; i++) begin
            do_push(32'h1000 + 32'(4 * i), nottaken, 32'h0);
        end
        check("t4_full", {31'b0, full}, 32'd1);
        check("t4_count_full", {28'b0, count}, 32'd8);
        do_push(32'h2000, nottaken, 32'h0);
        check("t4_count_after_drop", {28'b0, count}, 32'd8);
        expect_upd(32'h1000, 1'b0, 1'b0, 32'h1004);
        step(1'b1, 32'h1020, nottaken, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t4_count_push_pop_full", {28'b0, count}, 32'd8);
        check("t4_full_still", {31'b0, full}, 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            expect_upd(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h1004 + 32'(4 * i));
            do_resolve(1'b0, 32'h0);
        end
        check("t4_count_drained", {28'b0, count}, 32'd0);
        idle();

        // Resolve while empty, then pc+4 wrap
        do_resolve(1'b1, 32'h1234);
        check("t5_resolve_err", {31'b0, resolve_err}, 32'd1);
        idle();
        check("t5_no_upd", {31'b0, upd_en}, 32'd0);
        do_push(32'hFFFF_FFFC, taken, 32'h10);
        expect_upd(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000);
        do_resolve(1'b0, 32'h0);
        idle();
        check("t5_resolve_err_sticky", {31'b0, resolve_err}, 32'd1);

        // 13 pops so far, 3 of them mispredicted
`ifdef BRQ_STATS_EN
        check("stat_branches", stat_branches, 32'd13);
        check("stat_mispredicts", stat_mispredicts, 32'd3);
`else
        check("stat_branches_off", stat_branches, 32'd0);
        check("stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif

        // Reset mid-stream overrides a simultaneous push and resolve
        do_push(32'h700, taken, 32'h800);
        do_push(32'h704, nottaken, 32'h0);
        rst = 1'b1;
        step(1'b1, 32'h708, taken, 32'h900, 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        check("mid_rst_count", {28'b0, count}, 32'd0);
        check("mid_rst_empty", {31'b0, empty}, 32'd1);
        check("mid_rst_upd_en", {31'b0, upd_en}, 32'd0);
        check("mid_rst_upd_pc", upd_pc, 32'd0);
        check("mid_rst_redirect_pc", redirect_pc, 32'd0);
        check("mid_rst_resolve_err", {31'b0, resolve_err}, 32'd0);
        check("mid_rst_stat_branches", stat_branches, 32'd0);
        check("mid_rst_stat_mispredicts", stat_mispredicts, 32'd0);
        idle();
        idle();
        check("post_rst_upd_en", {31'b0, upd_en}, 32'd0);

        // Drain check
        idle();
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
